// File: rtl/fetch_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fetch_ctrl_pkg
// Shared constants and types for the instruction fetch controller:
//   INITIAL_ADDRESS     - PC loaded by reset
//   DEFAULT_IMEM_BASE   - lowest legal fetch address
//   DEFAULT_IMEM_SIZE   - size in bytes of the legal fetch window
//   fetch_state_t       - two-state fetch FSM encoding (ST_REQ / ST_WAIT)
//   EXC_ADEL            - exception flag value for an address-error fetch
//   fetch_entry_t       - one F/D buffer entry {instr, pc, exc}
//   is_bad_fetch()      - misaligned / out-of-window fetch address test
// -----------------------------------------------------------------------------
package fetch_ctrl_pkg;

   localparam logic [31:0] INITIAL_ADDRESS   = 32'h0000_3000;
   localparam logic [31:0] DEFAULT_IMEM_BASE = 32'h0000_3000;
   localparam logic [31:0] DEFAULT_IMEM_SIZE = 32'h0000_4000;

   typedef enum logic [0:0] {
      ST_REQ  = 1'b0,
      ST_WAIT = 1'b1
   } fetch_state_t;

   localparam logic EXC_ADEL = 1'b1;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        exc;
   } fetch_entry_t;

   // The upper bound is computed in 33 bits so a window that touches the top
   // of the address space does not wrap and reject everything.
   function automatic logic is_bad_fetch(input logic [31:0] pc,
                                         input logic [31:0] base,
                                         input logic [31:0] size);
      logic [32:0] limit;
      limit = {1'b0, base} + {1'b0, size};
      return (pc[1:0] != 2'b00) || (pc < base) || ({1'b0, pc} >= limit);
   endfunction

endpackage

// File: rtl/fetch_ctrl_buf.sv
// -----------------------------------------------------------------------------
// fetch_buf
// Single-entry F/D output buffer. Holds one fetched instruction (or an AdEL
// error entry) until decode consumes it.
// Ports:
//   clk, reset     - clock, synchronous active-high reset
//   stall_i        - decode frozen; a valid entry is not consumed
//   load_i         - write load_entry_i into the buffer this cycle
//   load_entry_i   - {instr, pc, exc} to be written
//   buf_free_o     - buffer is empty or being consumed this cycle
//   valid_o        - buffer holds an entry
//   instr_o        - buffered instruction word
//   pc_o           - PC of the buffered entry
//   exc_o          - buffered entry carries an AdEL fetch exception
// -----------------------------------------------------------------------------
module fetch_buf
   import fetch_ctrl_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic         stall_i,
   input  logic         load_i,
   input  fetch_entry_t load_entry_i,
   output logic         buf_free_o,
   output logic         valid_o,
   output logic [31:0]  instr_o,
   output logic [31:0]  pc_o,
   output logic         exc_o
);

   logic consume;

   // The entry leaves when decode is not stalled; a slot is therefore
   // available either when empty or when the current entry is leaving.
   always_comb begin
      consume    = valid_o && !stall_i;
      buf_free_o = !valid_o || !stall_i;
   end

   // A load in the same cycle as a consume simply replaces the entry, so
   // valid stays high; a consume alone empties the buffer. The data fields
   // are only rewritten on a load.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_o <= 1'b0;
         instr_o <= 32'h0;
         pc_o    <= 32'h0;
         exc_o   <= 1'b0;
      end else if (load_i) begin
         valid_o <= 1'b1;
         instr_o <= load_entry_i.instr;
         pc_o    <= load_entry_i.pc;
         exc_o   <= load_entry_i.exc;
      end else if (consume) begin
         valid_o <= 1'b0;
      end
   end

endmodule

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
// Fetch PC sequencer for the pipelined MIPS core. Issues one instruction
// memory request at a time, captures the response into the F/D buffer and
// applies branch/jump redirects with delay-slot semantics (the instruction
// already in flight completes; only the following fetch uses the target).
// Ports:
//   clk, reset         - clock, synchronous active-high reset
//   stall_i            - hazard unit freezes decode
//   redirect_valid_i   - one-cycle redirect pulse from decode
//   redirect_pc_i      - redirect target
//   imem_req_o         - memory request
//   imem_addr_o        - request address (same as pc_o)
//   imem_gnt_i         - memory accepted the request
//   imem_rvalid_i      - memory response valid
//   imem_rdata_i       - memory response data
//   pc_o               - current fetch PC
//   instr_valid_o      - F/D buffer holds an instruction
//   instr_o            - buffered instruction
//   instr_pc_o         - PC of buffered instruction
//   instr_exc_o        - AdEL exception on buffered instruction
// -----------------------------------------------------------------------------
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = INITIAL_ADDRESS,
   parameter logic [31:0] IMEM_BASE = DEFAULT_IMEM_BASE,
   parameter logic [31:0] IMEM_SIZE = DEFAULT_IMEM_SIZE
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall_i,
   input  logic        redirect_valid_i,
   input  logic [31:0] redirect_pc_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic [31:0] pc_o,
   output logic        instr_valid_o,
   output logic [31:0] instr_o,
   output logic [31:0] instr_pc_o,
   output logic        instr_exc_o
);

   fetch_state_t state_q;
   fetch_state_t state_d;
   logic [31:0]  pc_q;
   logic [31:0]  pc_next;
   logic         pend_valid_q;
   logic [31:0]  pend_pc_q;
   logic         buf_free;
   logic         bad;
   logic         advance;
   logic         load;
   fetch_entry_t load_entry;

   assign pc_o        = pc_q;
   assign imem_addr_o = pc_q;
   assign bad         = is_bad_fetch(pc_q, IMEM_BASE, IMEM_SIZE);

   fetch_buf u_buf (
      .clk          (clk),
      .reset        (reset),
      .stall_i      (stall_i),
      .load_i       (load),
      .load_entry_i (load_entry),
      .buf_free_o   (buf_free),
      .valid_o      (instr_valid_o),
      .instr_o      (instr_o),
      .pc_o         (instr_pc_o),
      .exc_o        (instr_exc_o)
   );

   // FSM state register. Reset always lands in ST_REQ, which abandons any
   // outstanding request: a late response is ignored because ST_REQ never
   // looks at rvalid.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_REQ;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: ST_REQ waits for an accepted request, ST_WAIT waits
   // for the single response. A bad PC never leaves ST_REQ because no
   // memory access is made for it.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_REQ: begin
            if (imem_req_o && imem_gnt_i) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (imem_rvalid_i) begin
               state_d = ST_REQ;
            end
         end
         default: state_d = ST_REQ;
      endcase
   end

   // Output logic. A request (or an AdEL error entry) is only produced when
   // the buffer has room, which is what guarantees a stalled entry is never
   // overwritten. The request is also held low during the reset cycle.
   always_comb begin
      imem_req_o = 1'b0;
      load       = 1'b0;
      advance    = 1'b0;
      load_entry = '0;
      case (state_q)
         ST_REQ: begin
            if (!reset && buf_free) begin
               if (bad) begin
                  load       = 1'b1;
                  advance    = 1'b1;
                  load_entry = '{instr: 32'h0, pc: pc_q, exc: EXC_ADEL};
               end else begin
                  imem_req_o = 1'b1;
               end
            end
         end
         ST_WAIT: begin
            if (imem_rvalid_i) begin
               load       = 1'b1;
               advance    = 1'b1;
               load_entry = '{instr: imem_rdata_i, pc: pc_q, exc: 1'b0};
            end
         end
         default: ;
      endcase
   end

   // Next fetch address. A redirect in the advancing cycle bypasses the
   // pending slot; otherwise a previously parked redirect is used before
   // falling back to sequential fetch.
   always_comb begin
      if (redirect_valid_i) begin
         pc_next = redirect_pc_i;
      end else if (pend_valid_q) begin
         pc_next = pend_pc_q;
      end else begin
         pc_next = pc_q + 32'd4;
      end
   end

   // PC and pending-redirect registers. A redirect that arrives while the
   // current fetch is still in progress is parked until the advance, so the
   // in-flight instruction becomes the delay slot. A later redirect before
   // the advance replaces the parked one.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q         <= RESET_PC;
         pend_valid_q <= 1'b0;
         pend_pc_q    <= 32'h0;
      end else if (advance) begin
         pc_q         <= pc_next;
         pend_valid_q <= 1'b0;
      end else if (redirect_valid_i) begin
         pend_valid_q <= 1'b1;
         pend_pc_q    <= redirect_pc_i;
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl
// Self-checking bench for fetch_ctrl. A single-cycle memory (grant with the
// request, response the following cycle) answers every fetch with a word
// derived from its address. A table of per-cycle vectors drives stall and
// redirect and lists the expected outputs; the reset-during-WAIT case is a
// hand-written sequence at the end.
// -----------------------------------------------------------------------------
module tb_fetch_ctrl;

   typedef struct {
      logic        stall;
      logic        rv;
      logic [31:0] rpc;
      logic        expReq;
      logic [31:0] expPc;
      logic        expValid;
      logic [31:0] expIpc;
      logic        expExc;
   } vec_t;

   logic        clk;
   logic        reset;
   logic        stall_i;
   logic        redirect_valid_i;
   logic [31:0] redirect_pc_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic [31:0] pc_o;
   logic        instr_valid_o;
   logic [31:0] instr_o;
   logic [31:0] instr_pc_o;
   logic        instr_exc_o;

   logic        memRvalid;
   logic [31:0] memRdata;
   logic        staleRvalid;

   int checks;
   int failures;

   vec_t vecs[$];

   fetch_ctrl dut (
      .clk              (clk),
      .reset            (reset),
      .stall_i          (stall_i),
      .redirect_valid_i (redirect_valid_i),
      .redirect_pc_i    (redirect_pc_i),
      .imem_req_o       (imem_req_o),
      .imem_addr_o      (imem_addr_o),
      .imem_gnt_i       (imem_gnt_i),
      .imem_rvalid_i    (imem_rvalid_i),
      .imem_rdata_i     (imem_rdata_i),
      .pc_o             (pc_o),
      .instr_valid_o    (instr_valid_o),
      .instr_o          (instr_o),
      .instr_pc_o       (instr_pc_o),
      .instr_exc_o      (instr_exc_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory contents are a fixed scramble of the address.
   function automatic logic [31:0] memWord(input logic [31:0] addr);
      return addr ^ 32'hC0DE_0000;
   endfunction

   // Single-cycle memory: grant alongside the request, respond next cycle.
   // staleRvalid injects a spurious response with junk data.
   assign imem_gnt_i    = imem_req_o;
   assign imem_rvalid_i = memRvalid | staleRvalid;
   assign imem_rdata_i  = staleRvalid ? 32'hBAD0_BAD0 : memRdata;

   always @(posedge clk) begin
      memRvalid <= imem_req_o && imem_gnt_i;
      memRdata  <= memWord(imem_addr_o);
   end

   function automatic vec_t mk(input logic stall, input logic rv,
                               input logic [31:0] rpc, input logic req,
                               input logic [31:0] pc, input logic valid,
                               input logic [31:0] ipc, input logic exc);
      vec_t v;
      v.stall = stall; v.rv = rv; v.rpc = rpc;
      v.expReq = req; v.expPc = pc; v.expValid = valid;
      v.expIpc = ipc; v.expExc = exc;
      return v;
   endfunction

   task automatic checkVal(input string name, input logic [31:0] act,
                           input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      stall_i          = v.stall;
      redirect_valid_i = v.rv;
      redirect_pc_i    = v.rpc;
   endtask

   task automatic checkOutput(input vec_t v, input int idx);
      string tag;
      tag = $sformatf("vec%0d", idx);
      checkVal({tag, ".req"}, {31'h0, imem_req_o}, {31'h0, v.expReq});
      checkVal({tag, ".pc"}, pc_o, v.expPc);
      checkVal({tag, ".addr"}, imem_addr_o, v.expPc);
      checkVal({tag, ".valid"}, {31'h0, instr_valid_o}, {31'h0, v.expValid});
      if (v.expValid) begin
         checkVal({tag, ".ipc"}, instr_pc_o, v.expIpc);
         checkVal({tag, ".exc"}, {31'h0, instr_exc_o}, {31'h0, v.expExc});
         checkVal({tag, ".instr"}, instr_o, v.expExc ? 32'h0 : memWord(v.expIpc));
      end
   endtask

   initial begin
      checks           = 0;
      failures         = 0;
      reset            = 1'b1;
      stall_i          = 1'b0;
      redirect_valid_i = 1'b0;
      redirect_pc_i    = 32'h0;
      staleRvalid      = 1'b0;
      memRvalid        = 1'b0;
      memRdata         = 32'h0;

      // Free run: 3000, 3004, then buffer at 3004 stalled 5 cycles.
      vecs.push_back(mk(0, 0, 0, 1, 32'h3000, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 32'h3000, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 32'h3004, 1, 32'h3000, 0));
      vecs.push_back(mk(0, 0, 0, 0, 32'h3004, 0, 0, 0));
      for (int i = 0; i < 5; i++)
         vecs.push_back(mk(1, 0, 0, 0, 32'h3008, 1, 32'h3004, 0));
      // Release: request for 3008 in the same cycle 3004 is consumed.
      vecs.push_back(mk(0, 0, 0, 1, 32'h3008, 1, 32'h3004, 0));
      vecs.push_back(mk(0, 0, 0, 0, 32'h3008, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 32'h300C, 1, 32'h3008, 0));
      vecs.push_back(mk(0, 0, 0, 0, 32'h300C, 0, 0, 0));
      // Redirect to 3100 while 3010 is in flight: 3010 is the delay slot.
      vecs.push_back(mk(0, 1, 32'h3100, 1, 32'h3010, 1, 32'h300C, 0));
      vecs.push_back(mk(0, 0, 0, 0, 32'h3010, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 32'h3100, 1, 32'h3010, 0));
      vecs.push_back(mk(0, 0, 0, 0, 32'h3100, 0, 0, 0));
      // Steer to 3020, then redirect to 3200 in the rvalid cycle (bypass).
      vecs.push_back(mk(0, 1, 32'h3020, 1, 32'h3104, 1, 32'h3100, 0));
      vecs.push_back(mk(0, 0, 0, 0, 32'h3104, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 32'h3020, 1, 32'h3104, 0));
      vecs.push_back(mk(0, 1, 32'h3200, 0, 32'h3020, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 32'h3200, 1, 32'h3020, 0));
      // No stale pending redirect: the next advance is sequential.
      vecs.push_back(mk(0, 0, 0, 0, 32'h3200, 0, 0, 0));
      // Misaligned 3002 then below-window 2000: AdEL entries, no request.
      vecs.push_back(mk(0, 1, 32'h3002, 1, 32'h3204, 1, 32'h3200, 0));
      vecs.push_back(mk(0, 0, 0, 0, 32'h3204, 0, 0, 0));
      vecs.push_back(mk(0, 1, 32'h2000, 0, 32'h3002, 1, 32'h3204, 0));
      vecs.push_back(mk(0, 1, 32'h3000, 0, 32'h2000, 1, 32'h3002, 1));
      vecs.push_back(mk(0, 0, 0, 1, 32'h3000, 1, 32'h2000, 1));
      vecs.push_back(mk(0, 0, 0, 0, 32'h3000, 0, 0, 0));
      // Upper edge: 6FFC is the last legal word, 7000 is out of window.
      vecs.push_back(mk(0, 1, 32'h6FFC, 1, 32'h3004, 1, 32'h3000, 0));
      vecs.push_back(mk(0, 0, 0, 0, 32'h3004, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 32'h6FFC, 1, 32'h3004, 0));
      vecs.push_back(mk(0, 0, 0, 0, 32'h6FFC, 0, 0, 0));
      vecs.push_back(mk(0, 1, 32'h3000, 0, 32'h7000, 1, 32'h6FFC, 0));
      vecs.push_back(mk(0, 0, 0, 1, 32'h3000, 1, 32'h7000, 1));

      // Reset cycle and reset values.
      @(posedge clk); #1;
      @(negedge clk);
      checkVal("rst.req", {31'h0, imem_req_o}, 32'h0);
      checkVal("rst.pc", pc_o, 32'h3000);
      checkVal("rst.valid", {31'h0, instr_valid_o}, 32'h0);
      checkVal("rst.instr", instr_o, 32'h0);
      checkVal("rst.ipc", instr_pc_o, 32'h0);
      checkVal("rst.exc", {31'h0, instr_exc_o}, 32'h0);
      @(posedge clk); #1;
      reset = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i]);
         @(negedge clk);
         checkOutput(vecs[i], i);
         @(posedge clk); #1;
      end
      stall_i          = 1'b0;
      redirect_valid_i = 1'b0;

      // Now in WAIT for 3000 with its response present; reset wins.
      reset = 1'b1;
      @(negedge clk);
      checkVal("wrst.req", {31'h0, imem_req_o}, 32'h0);
      @(posedge clk); #1;
      reset       = 1'b0;
      staleRvalid = 1'b1;
      @(negedge clk);
      checkVal("wrst.valid", {31'h0, instr_valid_o}, 32'h0);
      checkVal("wrst.instr", instr_o, 32'h0);
      checkVal("wrst.ipc", instr_pc_o, 32'h0);
      checkVal("wrst.exc", {31'h0, instr_exc_o}, 32'h0);
      checkVal("wrst.pc", pc_o, 32'h3000);
      checkVal("wrst.req1", {31'h0, imem_req_o}, 32'h1);
      checkVal("wrst.addr", imem_addr_o, 32'h3000);
      @(posedge clk); #1;
      staleRvalid = 1'b0;
      @(negedge clk);
      checkVal("stale.valid", {31'h0, instr_valid_o}, 32'h0);
      checkVal("stale.pc", pc_o, 32'h3000);
      @(posedge clk); #1;
      @(negedge clk);
      checkVal("post.valid", {31'h0, instr_valid_o}, 32'h1);
      checkVal("post.ipc", instr_pc_o, 32'h3000);
      checkVal("post.instr", instr_o, memWord(32'h3000));
      checkVal("post.exc", {31'h0, instr_exc_o}, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequences the fetch PC register for the pipelined MIPS core and owns the instruction-memory request/response handshake.
- Holds one fetched instruction in an F/D output buffer until decode consumes it.
- Applies branch/jump redirects with delay-slot semantics: the instruction in flight completes, and only the following fetch uses the target.
- Sits between the hazard unit / D-stage branch logic and the instruction memory.

Parameters:
- RESET_PC, 32'h0000_3000, fetch address after reset.
- IMEM_BASE, 32'h0000_3000, lowest legal fetch address.
- IMEM_SIZE, 32'h0000_4000, legal fetch window size in bytes.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- stall_i  in  1  hazard unit freezes D; output buffer is not consumed.
- redirect_valid_i  in  1  one-cycle pulse from D: the next fetch after the current one goes to redirect_pc_i.
- redirect_pc_i  in  32  branch/jump/jr target.
- imem_req_o  out  1  fetch request.
- imem_addr_o  out  32  fetch address; equals pc_o.
- imem_gnt_i  in  1  memory accepts request this cycle.
- imem_rvalid_i  in  1  response valid.
- imem_rdata_i  in  32  fetched instruction word.
- pc_o  out  32  current fetch PC.
- instr_valid_o  out  1  output buffer holds an instruction.
- instr_o  out  32  buffered instruction.
- instr_pc_o  out  32  PC of buffered instruction.
- instr_exc_o  out  1  AdEL fetch exception on buffered entry.

Behaviour:
- Reset:
  - pc=RESET_PC, state=REQ, pend_valid=0, pend_pc=0.
  - instr_valid_o=0, instr_o=0, instr_pc_o=0, instr_exc_o=0.
  - imem_req_o=0 in the reset cycle.
- Definitions:
  - buf_free = !instr_valid_o || !stall_i.
  - bad = (pc[1:0]!=0) || pc<IMEM_BASE || pc>=IMEM_BASE+IMEM_SIZE.
- FSM, two states, at most one outstanding request:
  - REQ: imem_req_o = !bad && buf_free.
    - Request accepted (req && gnt): go to WAIT.
    - bad && buf_free: no memory access. Buffer loads {instr=0, pc, exc=1}, PC advances, stay in REQ.
  - WAIT: imem_req_o=0; pc held. On imem_rvalid_i, buffer loads {imem_rdata_i, pc, exc=0}, PC advances, go to REQ.
  - imem_rvalid_i is ignored in REQ, which covers stale responses after reset.
- Buffer:
  - Consumed when instr_valid_o && !stall_i.
  - Consume and load in the same cycle: new entry wins, valid stays 1.
  - Consume without load: valid becomes 0.
  - Buffer is never overwritten while valid && stall_i; the request gating guarantees this.
- PC advance, in priority order:
  1. redirect_valid_i this cycle: redirect_pc_i (bypass).
  2. pend_valid: pend_pc.
  3. Otherwise: pc+4, with 32-bit wrap.
  - pend_valid clears on every advance.
- Redirect arriving in a cycle with no advance: pend_valid<=1, pend_pc<=redirect_pc_i. A second redirect before the advance overwrites pend_pc (later wins).
- A redirect never cancels the in-flight or buffered instruction; that instruction is the delay slot.
- Latency and throughput:
  - Single-cycle memory (gnt with req, rvalid next cycle): instruction valid 2 cycles after request issue.
  - Peak rate is one instruction per 2 cycles.
- Mid-operation reset abandons any outstanding request and clears the buffer and pend.

Decomposition:
- Shared constants file holds INITIAL_ADDRESS (=RESET_PC), the FSM state encodings ST_REQ/ST_WAIT, and EXC_ADEL.
- One natural sub-module: fetch_buf, the single-entry output buffer {instr, pc, exc, valid} with load/consume logic.
- fetch_ctrl keeps the FSM, pc and pend registers.

Test Plan:
- Memory model for all scenarios: gnt=1 with req, rvalid the following cycle.
- Reset then free run, no stall: requests at 0x3000, 0x3004, 0x3008. instr_pc_o sequence matches, each entry valid 2 cycles after its request, instr_o equals the memory contents.
- stall_i held high 5 cycles with buffer valid at 0x3004: imem_req_o=0, buffer and pc_o=0x3008 frozen. After release, the request for 0x3008 is issued the same cycle the buffer is consumed.
- Redirect to 0x3100 during WAIT for 0x3010: the 0x3010 instruction is delivered (delay slot), then the next request address is 0x3100, not 0x3014.
- Redirect to 0x3200 in the same cycle as rvalid for 0x3020: the next request is 0x3200 (bypass); pend_valid stays 0.
- Redirect to 0x3002, then to 0x2000: each delivers instr_valid_o=1, instr_o=0, instr_exc_o=1, instr_pc_o equal to the bad PC, with no imem_req_o for that PC.
- Assert reset while in WAIT, then drive a late rvalid: the late response is ignored, outputs are at their reset values, and the first request after reset is at 0x3000.
